iob_cache_be_mem: RTL and testbench
===================================

Name: iob_cache_be_mem

Overview:
- Back-end memory responder for the cache's native back-end port (BE_ADDR_W/BE_DATA_W side).
- Accepts native-bus requests from an initiator: req held until ack, wstrb≠0 means write.
- Services each request from an internal byte-enabled RAM after a fixed, parameterized latency.
- Used as the memory model behind iob_cache in simulation and in FPGA test harnesses.

Parameters:
- ADDR_W, 24: byte-address width of the back-end bus.
- DATA_W, 32: data width (power of two, ≥8).
- MEM_ADDR_W, 10: RAM depth in words, log2.
- LATENCY, 3: cycles from request acceptance to ack, ≥1.

Ports:
- clk  in  1  clock, all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- req  in  1  request; held high by the initiator until ack.
- addr  in  ADDR_W  byte address; the low log2(DATA_W/8) bits are ignored.
- wdata  in  DATA_W  write data.
- wstrb  in  DATA_W/8  byte write enables; all-zero means read.
- rdata  out  DATA_W  read data, valid in the ack cycle.
- ack  out  1  single-cycle completion pulse.

Behaviour:
- Reset: ack=0, rdata=0, FSM=IDLE, latency counter=0.
  - RAM contents are not reset; they are zero-initialised at simulation start.
  - A reset asserted mid-transaction aborts it: no RAM write, no ack.
- FSM states: IDLE, WAIT, RESP.
  - IDLE: if req=1, capture addr/wdata/wstrb into registers and load the counter with LATENCY-1. Go to RESP if LATENCY==1, else to WAIT.
  - WAIT: decrement the counter; go to RESP when the counter reaches 1.
  - RESP: ack=1 for exactly one cycle.
    - Write (captured wstrb≠0): commit the enabled bytes only; rdata holds its previous value.
    - Read: rdata = RAM word at the captured address. Registered, so it is valid in the ack cycle.
    - Next state is IDLE.
- Timing: acceptance at edge T gives ack high during cycle T+LATENCY. The next acceptance is at T+LATENCY+1 at the earliest, which gives back-to-back support for initiators that keep req high.
- rdata is stable between acks.
- Word index = addr[ADDR_LSB+MEM_ADDR_W-1:ADDR_LSB], with ADDR_LSB = log2(DATA_W/8).
  - Upper bits are ignored, so addresses alias modulo 2^MEM_ADDR_W words.
  - Index 2^MEM_ADDR_W-1 followed by 0 needs no special handling.
- Inputs are sampled only in IDLE. Changes to addr/wdata/wstrb during WAIT/RESP have no effect.
- If req is dropped during WAIT, the transaction still completes and acks. The responder does not check this protocol violation.
- Read after write to the same word (separate transactions) returns the new data; the write commits in RESP, before the next acceptance.
- A partial-strobe write (e.g. wstrb=4'b0010) leaves the other bytes unchanged.

Optional Feature:
- Macro: IOB_CACHE_BE_MEM_STALL_EN.
- Defined:
  - An 8-bit Fibonacci LFSR (taps 8,6,5,4; seed 8'hA5 on reset) advances every cycle.
  - At acceptance the counter loads LATENCY-1+lfsr[1:0], adding 0–3 random wait cycles. This stresses initiator tolerance of variable latency.
  - If LATENCY==1 and lfsr[1:0]≠0, the FSM goes through WAIT.
- Undefined: the LFSR is absent and the latency is exactly LATENCY on every transaction.

Decomposition:
- Package iob_cache_be_mem_pkg holds:
  - the state encoding constants (IDLE=2'd0, WAIT=2'd1, RESP=2'd2);
  - NBYTES = DATA_W/8 and ADDR_LSB = log2(NBYTES) as functions/localparams;
  - the LFSR seed and tap constants.
- One sub-module, iob_cache_be_mem_ram: single-port, byte-enabled, synchronous-read RAM (MEM_ADDR_W, DATA_W).
  - Write in the same cycle as en&|we.
  - Read data registered.
- The top holds the FSM, the counter, the capture registers and the optional LFSR.

Test Plan:
- Single write (LATENCY=3): addr=0x10, wdata=0xDEADBEEF, wstrb=4'hF, req held → ack exactly 3 cycles after acceptance, one cycle wide; word 4 = 0xDEADBEEF.
- Readback: read addr=0x10, wstrb=0 → ack after 3 cycles with rdata=0xDEADBEEF; rdata stays 0xDEADBEEF until the next read ack.
- Byte strobes: write 0x11223344 to addr 0x20, then write 0xAABBCCDD with wstrb=4'b0101 → read returns 0x11BB33DD.
- Back-to-back and wrap: keep req high; write words 0..9 with data i, then read addr = 4·2^MEM_ADDR_W + 4·3 → rdata=3 (aliasing); each acceptance lands exactly one cycle after the previous ack.
- Reset mid-operation: assert reset 1 cycle after accepting a write of 0xCAFEF00D to addr 0x40 → ack never asserts, rdata=0; a later read of 0x40 returns the prior content (0).
- STALL_EN build: 100 random read/write transactions against a bench scoreboard → every ack arrives LATENCY..LATENCY+3 cycles after acceptance, all read data matches, no missing or duplicate acks.

Source files
------------

// File: rtl/iob_cache_be_mem_pkg.sv
// Shared types and constants for the iob_cache back-end memory responder.
package iob_cache_be_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // Fibonacci LFSR, taps 8,6,5,4 expressed as a mask over bits [7:0]
    localparam logic [7:0] LFSR_SEED = 8'hA5;
    localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

    function automatic int nbytes(input int data_w);
        return data_w / 8;
    endfunction

    function automatic int addr_lsb(input int data_w);
        return $clog2(data_w / 8);
    endfunction

endpackage

// File: rtl/iob_cache_be_mem_ram.sv
// Single-port byte-enabled RAM with registered read data; contents start at zero.
module iob_cache_be_mem_ram
    import iob_cache_be_mem_pkg::*;
#(
    parameter int MEM_ADDR_W = 10,
    parameter int DATA_W     = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      en,
    input  logic [DATA_W/8-1:0]       we,
    input  logic [MEM_ADDR_W-1:0]     addr,
    input  logic [DATA_W-1:0]         wdata,
    output logic [DATA_W-1:0]         rdata
);
    localparam int NB = nbytes(DATA_W);

    logic [DATA_W-1:0] mem [2**MEM_ADDR_W] = '{default: '0};
    logic [DATA_W-1:0] rdata_q, rdata_d;

    always_ff @(posedge clk) begin
        if (en) begin
            for (int b = 0; b < NB; b++) begin
                if (we[b]) mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
            end
        end
    end

    // Write cycles leave the read register untouched
    always_comb begin
        rdata_d = rdata_q;
        if (en && !(|we)) rdata_d = mem[addr];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) rdata_q <= '0;
        else       rdata_q <= rdata_d;
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/iob_cache_be_mem.sv
// Native-bus memory responder with fixed latency; IOB_CACHE_BE_MEM_STALL_EN adds 0-3 random wait cycles.
module iob_cache_be_mem
    import iob_cache_be_mem_pkg::*;
#(
    parameter int ADDR_W     = 24,
    parameter int DATA_W     = 32,
    parameter int MEM_ADDR_W = 10,
    parameter int LATENCY    = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] wstrb,
    output logic [DATA_W-1:0]   rdata,
    output logic                ack
);
    localparam int NB    = nbytes(DATA_W);
    localparam int LSB   = addr_lsb(DATA_W);
    localparam int CNT_W = $clog2(LATENCY + 4);

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d, load;
    logic [MEM_ADDR_W-1:0]   idx_q, idx_d, ram_idx;
    logic [DATA_W-1:0]       wdata_q, wdata_d;
    logic [NB-1:0]           wstrb_q, wstrb_d, ram_we;
    logic                    ram_en, rd_go, unused_addr;

    assign unused_addr = ^addr;

`ifdef IOB_CACHE_BE_MEM_STALL_EN
    logic [7:0] lfsr_q, lfsr_d;

    always_comb lfsr_d = {lfsr_q[6:0], ^(lfsr_q & LFSR_TAPS)};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) lfsr_q <= LFSR_SEED;
        else       lfsr_q <= lfsr_d;
    end

    assign load = CNT_W'(LATENCY - 1) + CNT_W'(lfsr_q[1:0]);
`else
    assign load = CNT_W'(LATENCY - 1);
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        wstrb_d = wstrb_q;
        case (state_q)
            IDLE: begin
                if (req) begin
                    idx_d   = addr[LSB +: MEM_ADDR_W];
                    wdata_d = wdata;
                    wstrb_d = wstrb;
                    cnt_d   = load;
                    state_d = (load == '0) ? RESP : WAIT;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q <= CNT_W'(1)) state_d = RESP;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Reads are launched on the edge entering RESP so rdata is ready with ack;
    // writes commit during RESP itself.
    assign ram_idx = (state_q == IDLE) ? addr[LSB +: MEM_ADDR_W] : idx_q;
    assign rd_go   = (state_d == RESP) && (state_q != RESP) &&
                     ((state_q == IDLE) ? (wstrb == '0) : (wstrb_q == '0));
    assign ram_we  = (state_q == RESP) ? wstrb_q : '0;
    assign ram_en  = rd_go || (ram_we != '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
        end
    end

    iob_cache_be_mem_ram #(
        .MEM_ADDR_W (MEM_ADDR_W),
        .DATA_W     (DATA_W)
    ) u_ram (
        .clk   (clk),
        .reset (reset),
        .en    (ram_en),
        .we    (ram_we),
        .addr  (ram_idx),
        .wdata (wdata_q),
        .rdata (rdata)
    );

    assign ack = (state_q == RESP);

endmodule

// File: tb/tb_iob_cache_be_mem.sv
// Self-checking bench for iob_cache_be_mem against a word-array reference model.
module tb_iob_cache_be_mem;
    localparam int ADDR_W     = 24;
    localparam int DATA_W     = 32;
    localparam int MEM_ADDR_W = 10;
    localparam int LATENCY    = 3;
    localparam int DEPTH      = 2**MEM_ADDR_W;
`ifdef IOB_CACHE_BE_MEM_STALL_EN
    localparam int SLACK = 3;
`else
    localparam int SLACK = 0;
`endif

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              req = 1'b0;
    logic [ADDR_W-1:0] addr = '0;
    logic [31:0]       wdata = '0;
    logic [3:0]        wstrb = '0;
    logic [31:0]       rdata;
    logic              ack;

    int tests = 0;
    int fails = 0;
    int ack_cnt = 0;
    logic [31:0] model [DEPTH];

    iob_cache_be_mem #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_ADDR_W(MEM_ADDR_W), .LATENCY(LATENCY)
    ) dut (
        .clk(clk), .reset(reset), .req(req), .addr(addr), .wdata(wdata),
        .wstrb(wstrb), .rdata(rdata), .ack(ack)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (ack === 1'b1) ack_cnt++;

    function automatic int widx(input logic [ADDR_W-1:0] a);
        return (int'(a) / 4) % DEPTH;
    endfunction

    // Drives one transaction from a negedge; returns edges counted until ack (0 = timeout).
    task automatic run_txn(input logic [ADDR_W-1:0] a, input logic [31:0] d,
                           input logic [3:0] s, input bit keep,
                           output logic [31:0] rd, output int n);
        int w;
        req = 1'b1; addr = a; wdata = d; wstrb = s; n = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (ack === 1'b1) begin n = i + 1; break; end
        end
        rd = rdata;
        if (n != 0) begin
            w = widx(a);
            for (int b = 0; b < 4; b++)
                if (s[b]) model[w][b*8 +: 8] = d[b*8 +: 8];
        end
        if (!keep) begin
            req = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        tests++;
        if (ack !== 1'b0) begin fails++; $display("FAIL reset_ack got %b want 0", ack); end
        tests++;
        if (rdata !== 32'h0) begin fails++; $display("FAIL reset_rdata got %h want 0", rdata); end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single_write();
        logic [31:0] rd; int n;
        run_txn(24'h10, 32'hDEADBEEF, 4'hF, 1'b0, rd, n);
        tests++;
        if (n < LATENCY || n > LATENCY + SLACK) begin
            fails++; $display("FAIL write_latency got %0d want %0d..%0d", n, LATENCY, LATENCY + SLACK);
        end
        tests++;
        if (ack !== 1'b0) begin fails++; $display("FAIL ack_width got %b want 0", ack); end
    endtask

    task automatic test_readback();
        logic [31:0] rd, rd2; int n;
        run_txn(24'h10, 32'h0, 4'h0, 1'b0, rd, n);
        tests++;
        if (n < LATENCY || n > LATENCY + SLACK) begin
            fails++; $display("FAIL read_latency got %0d want %0d..%0d", n, LATENCY, LATENCY + SLACK);
        end
        tests++;
        if (rd !== 32'hDEADBEEF) begin fails++; $display("FAIL readback got %h want deadbeef", rd); end
        repeat (3) @(negedge clk);
        run_txn(24'h80, 32'h12345678, 4'hF, 1'b0, rd2, n);
        tests++;
        if (rdata !== 32'hDEADBEEF) begin
            fails++; $display("FAIL rdata_hold got %h want deadbeef", rdata);
        end
    endtask

    task automatic test_byte_strobes();
        logic [31:0] rd; int n;
        run_txn(24'h20, 32'h11223344, 4'hF, 1'b0, rd, n);
        run_txn(24'h20, 32'hAABBCCDD, 4'b0101, 1'b0, rd, n);
        run_txn(24'h20, 32'h0, 4'h0, 1'b0, rd, n);
        tests++;
        if (rd !== 32'h11BB33DD) begin fails++; $display("FAIL byte_strobe got %h want 11bb33dd", rd); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd; int n, want;
        for (int i = 0; i < 10; i++) begin
            run_txn(ADDR_W'(4 * i), 32'(i), 4'hF, 1'b1, rd, n);
            want = LATENCY + ((i == 0) ? 0 : 1);
            tests++;
            if (n < want || n > want + SLACK) begin
                fails++; $display("FAIL b2b_latency[%0d] got %0d want %0d..%0d", i, n, want, want + SLACK);
            end
        end
        run_txn(ADDR_W'(4 * DEPTH + 12), 32'h0, 4'h0, 1'b0, rd, n);
        tests++;
        if (n < LATENCY + 1 || n > LATENCY + 1 + SLACK) begin
            fails++; $display("FAIL b2b_read_latency got %0d want %0d..%0d", n, LATENCY + 1, LATENCY + 1 + SLACK);
        end
        tests++;
        if (rd !== 32'd3) begin fails++; $display("FAIL alias_read got %h want 3", rd); end
    endtask

    task automatic test_reset_mid_op();
        logic [31:0] rd; int n, acks0;
        acks0 = ack_cnt;
        req = 1'b1; addr = 24'h40; wdata = 32'hCAFEF00D; wstrb = 4'hF;
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        req = 1'b0; wstrb = 4'h0;
        tests++;
        if (rdata !== 32'h0) begin fails++; $display("FAIL midreset_rdata got %h want 0", rdata); end
        @(negedge clk);
        reset = 1'b0;
        repeat (8) @(negedge clk);
        tests++;
        if (ack_cnt != acks0) begin fails++; $display("FAIL midreset_ack got %0d acks want 0", ack_cnt - acks0); end
        run_txn(24'h40, 32'h0, 4'h0, 1'b0, rd, n);
        tests++;
        if (rd !== 32'h0) begin fails++; $display("FAIL midreset_ram got %h want 0", rd); end
    endtask

    task automatic test_random();
        logic [31:0] rd, d, last_rd, exp; logic [ADDR_W-1:0] a; logic [3:0] s;
        int n, acks0, lo; bit keep, prev_keep;
        acks0 = ack_cnt; prev_keep = 1'b0; last_rd = rdata;
        for (int t = 0; t < 100; t++) begin
            a = ADDR_W'($urandom_range(0, 3) * 4096 + $urandom_range(0, 31) * 4 + $urandom_range(0, 3));
            d = $urandom;
            s = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
            keep = 1'($urandom_range(0, 1));
            exp = (s == 4'h0) ? model[widx(a)] : last_rd;
            run_txn(a, d, s, keep, rd, n);
            lo = LATENCY + (prev_keep ? 1 : 0);
            tests++;
            if (n < lo || n > lo + SLACK) begin
                fails++; $display("FAIL rand_latency[%0d] got %0d want %0d..%0d", t, n, lo, lo + SLACK);
            end
            tests++;
            if (rd !== exp) begin
                fails++; $display("FAIL rand_rdata[%0d] addr %h got %h want %h", t, a, rd, exp);
            end
            last_rd = exp;
            prev_keep = keep;
        end
        req = 1'b0;
        repeat (2) @(negedge clk);
        tests++;
        if (ack_cnt - acks0 != 100) begin
            fails++; $display("FAIL rand_ack_count got %0d want 100", ack_cnt - acks0);
        end
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) model[i] = 32'h0;
        test_reset();
        test_single_write();
        test_readback();
        test_byte_strobes();
        test_back_to_back();
        test_reset_mid_op();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
